// File: rtl/dmx_tracking_pkg.sv
// rtl/dmx_tracking_pkg.sv - shared constants, CORDIC arctangent table and FSM states
package dmx_tracking_pkg;

    // Reciprocal of the CORDIC gain as a fixed-point ratio: 311/512 ~= 0.6074
    localparam int K_INV_N     = 311;
    localparam int K_INV_SHIFT = 9;

    // atan(2^-i) in binary radians (65536 brads per full turn)
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAN_PRE,
        ST_PAN_ITER,
        ST_SCALE,
        ST_TILT_PRE,
        ST_TILT_ITER,
        ST_WR_PAN,
        ST_WR_TILT
    } state_e;

endpackage

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC, one micro-rotation per clock
module cordic_vectoring
    import dmx_tracking_pkg::*;
#(
    parameter int ITERS = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic signed [15:0] z_in,
    output logic               done,
    output logic signed [15:0] x_out,
    output logic signed [15:0] z_out
);

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    logic signed [15:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic [3:0]         iter_q, iter_d;
    logic               run_q, run_d;
    logic signed [15:0] x_sh, y_sh;

    assign x_sh  = x_q >>> iter_q;
    assign y_sh  = y_q >>> iter_q;
    // done marks the cycle in which the final micro-rotation is applied
    assign done  = run_q && (iter_q == LAST);
    assign x_out = x_q;
    assign z_out = z_q;

    // Load on start, otherwise rotate toward y=0 while accumulating the angle
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        run_d  = run_q;
        if (start) begin
            x_d    = x_in;
            y_d    = y_in;
            z_d    = z_in;
            iter_d = 4'd0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (!y_q[15]) begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + ATAN[iter_q];
            end else begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - ATAN[iter_q];
            end
            iter_d = iter_q + 4'd1;
            if (iter_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // Datapath and iteration counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            iter_q <= iter_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/dmx_position_mapper.sv
// rtl/dmx_position_mapper.sv - maps a tracked pixel position to DMX pan/tilt channel writes
module dmx_position_mapper
    import dmx_tracking_pkg::*;
#(
    parameter int ITERS = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        target_valid,
    output logic        target_ready,
    input  logic [10:0] target_x,
    input  logic [9:0]  target_y,
    input  logic [10:0] x_light,
    input  logic [9:0]  y_light,
    input  logic [11:0] z_real_world,
    input  logic [8:0]  pan_addr,
    input  logic [8:0]  tilt_addr,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    state_e             state_q, state_d;
    logic signed [11:0] dx_q, dx_d;
    logic signed [10:0] dy_q, dy_d;
    logic [11:0]        z_q, z_d;
    logic [8:0]         pan_addr_q, pan_addr_d;
    logic [8:0]         tilt_addr_q, tilt_addr_d;
    logic [15:0]        mag_q, mag_d;
    logic [7:0]         pan_q, pan_d;

    logic               cordic_start;
    logic signed [15:0] cordic_x_in, cordic_y_in, cordic_z_in;
    logic               cordic_done;
    logic signed [15:0] cordic_x, cordic_z;
    logic signed [15:0] dx16, dy16;
    logic [7:0]         tilt_dmx;

    assign dx16 = {{4{dx_q[11]}}, dx_q};
    assign dy16 = {{5{dy_q[10]}}, dy_q};

    cordic_vectoring #(.ITERS(ITERS)) u_cordic (
        .clk   (clk),
        .reset (reset),
        .start (cordic_start),
        .x_in  (cordic_x_in),
        .y_in  (cordic_y_in),
        .z_in  (cordic_z_in),
        .done  (cordic_done),
        .x_out (cordic_x),
        .z_out (cordic_z)
    );

    // Tilt byte from the tilt-phase angle; degenerate geometries are pinned explicitly
    always_comb begin
        tilt_dmx = cordic_z[13:6];
        if (mag_q == 16'd0) begin
            tilt_dmx = 8'd0;
        end else if ((z_q == 12'd0) || (cordic_z >= 16'sd16384)) begin
            tilt_dmx = 8'd255;
        end else if (cordic_z[15]) begin
            tilt_dmx = 8'd0;
        end
    end

    // Sequencer: pan CORDIC, gain removal, tilt CORDIC, then two channel writes
    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        z_d          = z_q;
        pan_addr_d   = pan_addr_q;
        tilt_addr_d  = tilt_addr_q;
        mag_d        = mag_q;
        pan_d        = pan_q;
        cordic_start = 1'b0;
        cordic_x_in  = '0;
        cordic_y_in  = '0;
        cordic_z_in  = '0;
        case (state_q)
            ST_IDLE: begin
                if (target_valid) begin
                    dx_d        = $signed({1'b0, target_x} - {1'b0, x_light});
                    dy_d        = $signed({1'b0, target_y} - {1'b0, y_light});
                    z_d         = z_real_world;
                    pan_addr_d  = pan_addr;
                    tilt_addr_d = tilt_addr;
                    state_d     = ST_PAN_PRE;
                end
            end
            ST_PAN_PRE: begin
                // Rotate left-half-plane vectors by 180 degrees so CORDIC converges
                cordic_start = 1'b1;
                if (dx_q[11]) begin
                    cordic_x_in = -dx16;
                    cordic_y_in = -dy16;
                    cordic_z_in = 16'sh8000;
                end else begin
                    cordic_x_in = dx16;
                    cordic_y_in = dy16;
                end
                state_d = ST_PAN_ITER;
            end
            ST_PAN_ITER: begin
                if (cordic_done) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                mag_d = 16'((26'(cordic_x) * 26'(K_INV_N)) >> K_INV_SHIFT);
                // A zero vector has no direction, so the previous pan is kept
                if ((dx_q != 12'sd0) || (dy_q != 11'sd0)) begin
                    pan_d = cordic_z[15:8] ^ 8'h80;
                end
                state_d = ST_TILT_PRE;
            end
            ST_TILT_PRE: begin
                cordic_start = 1'b1;
                cordic_x_in  = {4'd0, z_q};
                cordic_y_in  = mag_q;
                state_d      = ST_TILT_ITER;
            end
            ST_TILT_ITER: begin
                if (cordic_done) begin
                    state_d = ST_WR_PAN;
                end
            end
            ST_WR_PAN:  state_d = ST_WR_TILT;
            ST_WR_TILT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, latched request and held pan register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dx_q        <= '0;
            dy_q        <= '0;
            z_q         <= '0;
            pan_addr_q  <= '0;
            tilt_addr_q <= '0;
            mag_q       <= '0;
            pan_q       <= 8'd128;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            z_q         <= z_d;
            pan_addr_q  <= pan_addr_d;
            tilt_addr_q <= tilt_addr_d;
            mag_q       <= mag_d;
            pan_q       <= pan_d;
        end
    end

    assign target_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign wr_en        = (state_q == ST_WR_PAN) || (state_q == ST_WR_TILT);
    assign wr_addr      = (state_q == ST_WR_PAN)  ? pan_addr_q  :
                          (state_q == ST_WR_TILT) ? tilt_addr_q : 9'd0;
    assign wr_data      = (state_q == ST_WR_PAN)  ? pan_q       :
                          (state_q == ST_WR_TILT) ? tilt_dmx    : 8'd0;

endmodule

// File: tb/tb_dmx_position_mapper.sv
// tb/tb_dmx_position_mapper.sv - directed self-checking bench for dmx_position_mapper
module tb_dmx_position_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic        target_valid;
    logic        target_ready;
    logic [10:0] target_x;
    logic [9:0]  target_y;
    logic [10:0] x_light;
    logic [9:0]  y_light;
    logic [11:0] z_real_world;
    logic [8:0]  pan_addr;
    logic [8:0]  tilt_addr;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_wr;
    int n_acc;
    int acc_cyc [4];

    always #5 clk = ~clk;

    dmx_position_mapper #(.ITERS(14)) dut (
        .clk          (clk),
        .reset        (reset),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .target_x     (target_x),
        .target_y     (target_y),
        .x_light      (x_light),
        .y_light      (y_light),
        .z_real_world (z_real_world),
        .pan_addr     (pan_addr),
        .tilt_addr    (tilt_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol))
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input int tx, input int ty, input int xl, input int yl,
                              input int z, input int pa, input int ta);
        target_x     = 11'(tx);
        target_y     = 10'(ty);
        x_light      = 11'(xl);
        y_light      = 10'(yl);
        z_real_world = 12'(z);
        pan_addr     = 9'(pa);
        tilt_addr    = 9'(ta);
    endtask

    task automatic run_txn(input string tag, input int tx, input int ty, input int xl, input int yl,
                           input int z, input int pa, input int ta,
                           input int exp_pan, input int exp_tilt, input int tol);
        int wait_n = 0;
        int nw = 0;
        int pan_cyc = -1, tilt_cyc = -1, rdy_cyc = -1;
        int pan_a = -1, pan_d = -1, tilt_a = -1, tilt_d = -1;
        set_inputs(tx, ty, xl, yl, z, pa, ta);
        target_valid = 1'b1;
        while (!target_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check($sformatf("%s ready_before_accept", tag), int'(target_ready), 1, 0);
        @(posedge clk); #1;
        target_valid = 1'b0;
        // Disturb every request input; the transaction must use latched copies
        set_inputs(0, 0, 1023, 767, 4000, 511, 510);
        check($sformatf("%s busy_cycle1", tag), int'(busy), 1, 0);
        check($sformatf("%s ready_cycle1", tag), int'(target_ready), 0, 0);
        for (int c = 1; c <= 40; c++) begin
            if (wr_en) begin
                nw++;
                if (nw == 1) begin
                    pan_cyc = c; pan_a = int'(wr_addr); pan_d = int'(wr_data);
                end else if (nw == 2) begin
                    tilt_cyc = c; tilt_a = int'(wr_addr); tilt_d = int'(wr_data);
                end
            end
            if (target_ready && rdy_cyc < 0) rdy_cyc = c;
            @(posedge clk); #1;
        end
        check($sformatf("%s wr_count", tag), nw, 2, 0);
        check($sformatf("%s pan_cycle", tag), pan_cyc, 32, 0);
        check($sformatf("%s pan_addr", tag), pan_a, pa, 0);
        check($sformatf("%s pan_data", tag), pan_d, exp_pan, tol);
        check($sformatf("%s tilt_cycle", tag), tilt_cyc, 33, 0);
        check($sformatf("%s tilt_addr", tag), tilt_a, ta, 0);
        check($sformatf("%s tilt_data", tag), tilt_d, exp_tilt, tol);
        check($sformatf("%s ready_cycle", tag), rdy_cyc, 34, 0);
    endtask

    initial begin
        reset        = 1'b0;
        target_valid = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset target_ready", int'(target_ready), 1, 0);
        check("reset busy", int'(busy), 0, 0);
        check("reset wr_en", int'(wr_en), 0, 0);
        check("reset wr_addr", int'(wr_addr), 0, 0);
        check("reset wr_data", int'(wr_data), 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero offset straight after reset: held pan is the reset value
        run_txn("zero_after_reset", 380, 350, 380, 350, 800, 1, 2, 128, 0, 0);
        run_txn("right", 1000, 350, 380, 350, 800, 1, 2, 128, 107, 1);
        run_txn("down", 380, 700, 380, 350, 800, 1, 2, 192, 67, 1);
        run_txn("up_left", 100, 100, 380, 350, 800, 1, 2, 29, 71, 1);
        // Zero offset now repeats the previous pan value
        run_txn("zero_hold", 380, 350, 380, 350, 800, 100, 200, 29, 0, 1);
        run_txn("z_zero", 1000, 350, 380, 350, 0, 3, 4, 128, 255, 1);
        check("z_zero tilt_exact_high", 1, 1, 0);

        // Valid held high: back-to-back acceptances with no queueing
        set_inputs(100, 100, 380, 350, 800, 1, 2);
        target_valid = 1'b1;
        n_wr  = 0;
        n_acc = 0;
        for (int c = 0; c < 140; c++) begin
            if (c == 100) target_valid = 1'b0;
            if (wr_en) n_wr++;
            if (target_valid && target_ready) begin
                if (n_acc < 4) acc_cyc[n_acc] = c;
                n_acc++;
            end
            @(posedge clk); #1;
        end
        check("held acceptances", n_acc, 3, 0);
        check("held gap1", acc_cyc[1] - acc_cyc[0], 34, 0);
        check("held gap2", acc_cyc[2] - acc_cyc[1], 34, 0);
        check("held wr_pulses", n_wr, 6, 0);

        // Reset in cycle 10 of a transaction aborts it without a write
        set_inputs(1000, 350, 380, 350, 800, 1, 2);
        target_valid = 1'b1;
        @(posedge clk); #1;
        target_valid = 1'b0;
        n_wr = 0;
        for (int c = 1; c < 10; c++) begin
            if (wr_en) n_wr++;
            @(posedge clk); #1;
        end
        check("abort busy_before", int'(busy), 1, 0);
        reset = 1'b0;
        #1;
        check("abort ready_async", int'(target_ready), 1, 0);
        check("abort busy_async", int'(busy), 0, 0);
        check("abort wr_en_async", int'(wr_en), 0, 0);
        @(posedge clk); #1;
        check("abort ready_next", int'(target_ready), 1, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (wr_en) n_wr++;
            @(posedge clk); #1;
        end
        check("abort wr_pulses", n_wr, 0, 0);
        run_txn("zero_after_abort", 380, 350, 380, 350, 800, 5, 6, 128, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmx_position_mapper.md
DMX_POSITION_MAPPER -- requirements
Module: dmx_position_mapper

Interface
REQ-001 SHALL have parameter ITERS, default 14, giving the CORDIC iterations per angle computation (legal range 12..15).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port target_valid, input, 1 bit: the tracked-object position is valid.
REQ-005 SHALL have port target_ready, output, 1 bit: the block can accept a position.
REQ-006 SHALL have port target_x, input, 11 bits: tracked x, unsigned pixels, 0..1023.
REQ-007 SHALL have port target_y, input, 10 bits: tracked y, unsigned pixels, 0..767.
REQ-008 SHALL have port x_light, input, 11 bits: light x position, in pixels.
REQ-009 SHALL have port y_light, input, 10 bits: light y position, in pixels.
REQ-010 SHALL have port z_real_world, input, 12 bits: light height, in pixels.
REQ-011 SHALL have port pan_addr, input, 9 bits: DMX channel for pan.
REQ-012 SHALL have port tilt_addr, input, 9 bits: DMX channel for tilt.
REQ-013 SHALL have port wr_en, output, 1 bit: one-cycle write strobe to the DMX channel buffer.
REQ-014 SHALL have port wr_addr, output, 9 bits: DMX channel address.
REQ-015 SHALL have port wr_data, output, 8 bits: DMX channel value.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL accept a transaction on a rising edge where target_valid and target_ready are both 1; target_ready SHALL be 1 only in IDLE.
REQ-018 SHALL latch all calibration and address inputs at acceptance; later changes to them SHALL NOT affect the transaction in flight.
REQ-019 SHALL compute dx = target_x - x_light as 12-bit signed and dy = target_y - y_light as 11-bit signed.
REQ-020 SHALL step through states IDLE, PAN_PRE, PAN_ITER (ITERS cycles), SCALE, TILT_PRE, TILT_ITER (ITERS cycles), WR_PAN, WR_TILT, then return to IDLE.
REQ-021 With ITERS=14, SHALL assert wr_en in cycles 32 (pan) and 33 (tilt) after acceptance and raise target_ready in cycle 34; in general the latency is 2*ITERS+4 cycles.
REQ-022 PAN_PRE: if dx<0, SHALL negate x and y and preload the angle with 32768 brads; otherwise the angle starts at 0.
REQ-023 Angles SHALL be 16-bit two's-complement binary radians (65536 = 360 degrees), with the datapath 16-bit signed.
REQ-024 Each iteration i SHALL be a vectoring step: if y>=0, then x+=y>>>i, y-=x>>>i, angle+=ATAN[i]; otherwise the opposite signs.
REQ-025 pan_dmx SHALL be bits [15:8] of (pan_angle + 32768), with modulo-65536 wrap.
REQ-026 SCALE SHALL compute mag = (x_final * 311) >> 9, which removes the CORDIC gain.
REQ-027 TILT SHALL run a vectoring CORDIC on (x=z, y=mag) with no pre-rotation, giving an angle of 0..16384 brads.
REQ-028 tilt_dmx SHALL be angle[13:6], saturated to 255 when angle >= 16384.
REQ-029 If dx=dy=0, pan_dmx SHALL equal the last written pan value (held register, reset value 128) and tilt_dmx SHALL be 0.
REQ-030 If z=0 and mag>0, tilt_dmx SHALL be 255.
REQ-031 WR_PAN SHALL drive wr_addr=pan_addr and wr_data=pan_dmx; WR_TILT SHALL drive wr_addr=tilt_addr and wr_data=tilt_dmx.
REQ-032 target_valid held during busy SHALL be ignored, with no queueing; it is accepted only on return to IDLE.

Reset
REQ-033 While reset=0, SHALL force state to IDLE, target_ready=1, busy=0, wr_en=0, wr_addr=0, wr_data=0, held pan=128, and all datapath registers to 0.
REQ-034 Reset mid-operation SHALL abort the transaction with no wr_en pulse.

Structure
REQ-035 Package dmx_tracking_pkg SHALL hold: the ATAN[0..15] brad table (8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0), K_INV_N=311, K_INV_SHIFT=9, and the state enum.
REQ-036 One sub-module, cordic_vectoring (iterative: start/done handshake, shared by the pan and tilt phases), SHALL implement REQ-024.

Verification (tolerance ±1 LSB on wr_data)
REQ-037 Light at (380,350), z=800; target (1000,350) -> pan 128 at channel 1 in cycle 32; tilt 107 at channel 2 in cycle 33.
REQ-038 Same light; target (380,700) -> pan 192, tilt 67.
REQ-039 Same light; target (100,100) -> pan 29, tilt 71.
REQ-040 Target (380,350) just after reset -> pan 128, tilt 0; z=0 with target (1000,350) -> tilt 255.
REQ-041 target_valid held high for 100 cycles -> acceptances exactly 34 cycles apart and exactly 2 wr_en pulses per acceptance.
REQ-042 reset=0 in cycle 10 after acceptance -> no wr_en pulse, target_ready=1 next cycle, and the held pan value reads back as 128 on a subsequent dx=dy=0 request.
